// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU-side memory command bus.
//   mem_cmd    : one-hot command (001 NONE, 010 READ, 100 WRITE), requester-driven
//   mem_addr   : word address, requester-driven
//   write_data : store data, requester-driven
//   read_data  : registered load data, responder-driven
//   mem_ready  : one-cycle completion pulse, responder-driven
// Handshake: the requester presents a command and holds mem_cmd/mem_addr/
// write_data stable at least for the cycle in which the responder is idle
// (it may hold them until mem_ready). mem_ready is high for exactly one cycle
// per accepted command; read_data is valid from that cycle until the next read.
interface mem_responder_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) ();
  logic [2:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              mem_ready;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, mem_ready
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, mem_ready
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: memory-side target for the CPU one-hot memory command bus.
// Serves reads/writes from an internal word RAM (lower half of the address
// space) and memory-mapped I/O (LED register, synchronized switches) in the
// upper half, completing after WAIT_STATES extra cycles.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   bus       : mem_responder_if slave modport (command bus)
//   sw        : asynchronous switch inputs
//   led       : LED register
//   cmd_err   : sticky error flag (illegal command or unmapped access)
//   dbg_state : current FSM state (0 IDLE, 1 WAIT, 2 DONE)
module mem_responder #(
  parameter int          ADDR_W      = 9,
  parameter int          DATA_W      = 16,
  parameter int          WAIT_STATES = 1,
  parameter int unsigned LED_ADDR    = 'h100,
  parameter int unsigned SW_ADDR     = 'h140
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_responder_if.slave    bus,
  input  logic [7:0]        sw,
  output logic [7:0]        led,
  output logic              cmd_err,
  output logic [1:0]        dbg_state
);

  localparam logic [2:0] CMD_NONE  = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam int         RAM_WORDS = 2 ** (ADDR_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [3:0]        cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] read_data_q;
  logic [7:0]        sw_meta, sw_sync;
  logic [DATA_W-1:0] ram [0:RAM_WORDS-1];

  logic              cmd_start;
  logic              do_access;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_is_ram;

  assign cmd_start = (bus.mem_cmd == CMD_READ) || (bus.mem_cmd == CMD_WRITE);

  // With zero wait states the access happens on the same edge that captures
  // the command, so the access operands come straight from the bus in IDLE.
  assign acc_write  = (state == S_IDLE) ? (bus.mem_cmd == CMD_WRITE) : wr_q;
  assign acc_addr   = (state == S_IDLE) ? bus.mem_addr   : addr_q;
  assign acc_wdata  = (state == S_IDLE) ? bus.write_data : wdata_q;
  assign acc_is_ram = ~acc_addr[ADDR_W-1];

  // Access fires on the edge entering DONE; reset at that edge suppresses it.
  assign do_access = rst_n && (next_state == S_DONE) && (state != S_DONE);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (cmd_start) next_state = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
      S_WAIT:  if (cnt == 4'd1) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      led         <= 8'd0;
      cmd_err     <= 1'b0;
      sw_meta     <= 8'd0;
      sw_sync     <= 8'd0;
    end else begin
      state   <= next_state;
      sw_meta <= sw;
      sw_sync <= sw_meta;

      if (state == S_IDLE) begin
        if (cmd_start) begin
          wr_q    <= (bus.mem_cmd == CMD_WRITE);
          addr_q  <= bus.mem_addr;
          wdata_q <= bus.write_data;
          cnt     <= 4'(WAIT_STATES);
        end else if (bus.mem_cmd != CMD_NONE) begin
          cmd_err <= 1'b1;
        end
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (do_access) begin
        if (acc_is_ram) begin
          if (!acc_write) read_data_q <= ram[acc_addr[ADDR_W-2:0]];
        end else if (acc_addr == ADDR_W'(LED_ADDR)) begin
          if (acc_write) led <= acc_wdata[7:0];
          else           read_data_q <= DATA_W'(led);
        end else if (acc_addr == ADDR_W'(SW_ADDR)) begin
          // Writes to the switch port are silently ignored.
          if (!acc_write) read_data_q <= DATA_W'(sw_sync);
        end else begin
          cmd_err <= 1'b1;
          if (!acc_write) read_data_q <= '0;
        end
      end
    end
  end

  // RAM has no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (do_access && acc_write && acc_is_ram)
      ram[acc_addr[ADDR_W-2:0]] <= acc_wdata;
  end

  assign bus.read_data = read_data_q;
  assign bus.mem_ready = (state == S_DONE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam logic [2:0] CMD_NONE  = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cmd;
  logic [8:0]  addr;
  logic [15:0] wdata;
  logic [7:0]  sw;
  int          sel;
  int          errors = 0;
  int          checks = 0;

  logic [7:0]  led0, led1, led3;
  logic        err0, err1, err3;
  logic [1:0]  st0, st1, st3;
  logic        rdy;
  logic [15:0] rdata;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(9), .DATA_W(16)) b0 ();
  mem_responder_if #(.ADDR_W(9), .DATA_W(16)) b1 ();
  mem_responder_if #(.ADDR_W(9), .DATA_W(16)) b3 ();

  assign b0.mem_cmd = (sel == 0) ? cmd : CMD_NONE;
  assign b1.mem_cmd = (sel == 1) ? cmd : CMD_NONE;
  assign b3.mem_cmd = (sel == 3) ? cmd : CMD_NONE;
  assign b0.mem_addr = addr;
  assign b1.mem_addr = addr;
  assign b3.mem_addr = addr;
  assign b0.write_data = wdata;
  assign b1.write_data = wdata;
  assign b3.write_data = wdata;

  assign rdy   = (sel == 0) ? b0.mem_ready : (sel == 3) ? b3.mem_ready : b1.mem_ready;
  assign rdata = (sel == 0) ? b0.read_data : (sel == 3) ? b3.read_data : b1.read_data;

  mem_responder #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .sw(sw),
    .led(led0), .cmd_err(err0), .dbg_state(st0)
  );
  mem_responder #(.WAIT_STATES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .sw(sw),
    .led(led1), .cmd_err(err1), .dbg_state(st1)
  );
  mem_responder #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .sw(sw),
    .led(led3), .cmd_err(err3), .dbg_state(st3)
  );

  // Driver: presents a command in the cycle after the next rising edge, holds
  // it until mem_ready is seen at a falling edge, then drops to NONE.
  // lat is the cycle index of ready (0 = presenting cycle), -1 on timeout.
  task automatic issue(input logic [2:0] c, input logic [8:0] a,
                       input logic [15:0] d, output int lat);
    lat = -1;
    @(posedge clk); #1;
    cmd = c; addr = a; wdata = d;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        lat = k;
        break;
      end
    end
    cmd = CMD_NONE;
  endtask

  task automatic test_reset;
    sel = 1;
    rst_n = 1'b0;
    cmd = 3'($urandom_range(0, 7)); addr = 9'($urandom); wdata = 16'($urandom);
    sw = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      cmd = 3'($urandom_range(0, 7)); addr = 9'($urandom); wdata = 16'($urandom);
      sw = 8'($urandom);
    end
    @(negedge clk);
    checks++; if ({b0.read_data, b1.read_data, b3.read_data} !== 48'd0) begin errors++; $display("FAIL reset_read_data got %h/%h/%h want 0", b0.read_data, b1.read_data, b3.read_data); end
    checks++; if ({led0, led1, led3} !== 24'd0) begin errors++; $display("FAIL reset_led got %h/%h/%h want 0", led0, led1, led3); end
    checks++; if ({b0.mem_ready, b1.mem_ready, b3.mem_ready} !== 3'b000) begin errors++; $display("FAIL reset_ready got %b%b%b want 000", b0.mem_ready, b1.mem_ready, b3.mem_ready); end
    checks++; if ({err0, err1, err3} !== 3'b000) begin errors++; $display("FAIL reset_cmd_err got %b%b%b want 000", err0, err1, err3); end
    checks++; if ({st0, st1, st3} !== 6'd0) begin errors++; $display("FAIL reset_state got %0d/%0d/%0d want IDLE", st0, st1, st3); end
    cmd = CMD_NONE; sw = 8'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_ram_rw;
    int lat;
    sel = 1;
    issue(CMD_WRITE, 9'h005, 16'hBEEF, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL ws1_write_latency got %0d want 2", lat); end
    issue(CMD_READ, 9'h005, 16'h0000, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL ws1_read_latency got %0d want 2", lat); end
    checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL ws1_read_data got %h want beef", rdata); end
    repeat (3) @(negedge clk);
    checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL ws1_read_hold got %h want beef", rdata); end
    issue(CMD_WRITE, 9'h006, 16'h1111, lat);
    checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL write_keeps_read_data got %h want beef", rdata); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL ram_no_err got %b want 0", err1); end
  endtask

  task automatic test_mmio;
    int lat;
    sel = 1;
    issue(CMD_WRITE, 9'h000, 16'h5A5A, lat);
    issue(CMD_WRITE, 9'h100, 16'h12A5, lat);
    checks++; if (led1 !== 8'hA5) begin errors++; $display("FAIL led_write got %h want a5", led1); end
    issue(CMD_READ, 9'h000, 16'h0000, lat);
    checks++; if (rdata !== 16'h5A5A) begin errors++; $display("FAIL led_not_in_ram got %h want 5a5a", rdata); end
    issue(CMD_READ, 9'h100, 16'h0000, lat);
    checks++; if (rdata !== 16'h00A5) begin errors++; $display("FAIL led_read got %h want 00a5", rdata); end
    sw = 8'h3C;
    repeat (4) @(posedge clk);
    issue(CMD_READ, 9'h140, 16'h0000, lat);
    checks++; if (rdata !== 16'h003C) begin errors++; $display("FAIL sw_read got %h want 003c", rdata); end
    issue(CMD_WRITE, 9'h140, 16'hFFFF, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL sw_write_latency got %0d want 2", lat); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL sw_write_no_err got %b want 0", err1); end
  endtask

  task automatic test_zero_wait;
    int lat;
    logic exp_rdy;
    sel = 0;
    issue(CMD_WRITE, 9'h020, 16'h0F0F, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL ws0_write_latency got %0d want 1", lat); end
    @(posedge clk); #1;
    cmd = CMD_READ; addr = 9'h020;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_rdy = (k % 2 == 1);
      checks++; if (rdy !== exp_rdy) begin errors++; $display("FAIL ws0_ready_cycle%0d got %b want %b", k, rdy, exp_rdy); end
      if (exp_rdy) begin
        checks++; if (rdata !== 16'h0F0F) begin errors++; $display("FAIL ws0_read_data_cycle%0d got %h want 0f0f", k, rdata); end
      end
    end
    cmd = CMD_NONE;
  endtask

  task automatic test_errors;
    int lat;
    sel = 1;
    @(posedge clk); #1;
    cmd = 3'b011;
    @(posedge clk); #1;
    cmd = CMD_NONE;
    @(negedge clk);
    checks++; if (st1 !== 2'd0) begin errors++; $display("FAIL illegal_no_txn state got %0d want 0", st1); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL illegal_no_ready got %b want 0", rdy); end
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL illegal_sets_err got %b want 1", err1); end
    repeat (3) @(negedge clk);
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err1); end

    sel = 3;
    issue(CMD_WRITE, 9'h030, 16'h7777, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL ws3_write_latency got %0d want 4", lat); end
    issue(CMD_READ, 9'h030, 16'h0000, lat);
    checks++; if (rdata !== 16'h7777) begin errors++; $display("FAIL ws3_read_data got %h want 7777", rdata); end
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL ws3_err_clear got %b want 0", err3); end
    issue(CMD_READ, 9'h1F0, 16'h0000, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL unmapped_latency got %0d want 4", lat); end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL unmapped_read got %h want 0000", rdata); end
    checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL unmapped_err got %b want 1", err3); end
  endtask

  task automatic test_reset_mid_write;
    int   lat;
    logic seen;
    sel = 3;
    issue(CMD_WRITE, 9'h010, 16'hAAAA, lat);
    seen = 1'b0;
    @(posedge clk); #1;
    cmd = CMD_WRITE; addr = 9'h010; wdata = 16'h1234;
    @(negedge clk); if (rdy !== 1'b0) seen = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); if (rdy !== 1'b0) seen = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; cmd = CMD_NONE;
    @(negedge clk); if (rdy !== 1'b0) seen = 1'b1;
    checks++; if (st3 !== 2'd1) begin errors++; $display("FAIL mid_write_in_wait state got %0d want 1", st3); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); if (rdy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_write_no_ready got %b want 0", seen); end
    issue(CMD_READ, 9'h010, 16'h0000, lat);
    checks++; if (rdata !== 16'hAAAA) begin errors++; $display("FAIL mid_write_discarded got %h want aaaa", rdata); end
  endtask

  initial begin
    sel = 1; cmd = CMD_NONE; addr = '0; wdata = '0; sw = '0; rst_n = 1'b0;
    test_reset();
    test_ram_rw();
    test_mmio();
    test_zero_wait();
    test_errors();
    test_reset_mid_write();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
